// File: rtl/ps2_pkg.sv
// ps2_pkg: shared frame states, scancode constants and timeout sizing for the PS/2 receiver.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    function automatic int timeout_cycles(input int freq_hz, input int us);
        return int'((longint'(freq_hz) * longint'(us)) / 64'd1_000_000);
    endfunction
endpackage

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: synchronizes the raw PS/2 pins and glitch-filters the clock into a falling-edge strobe.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic fall_o,
    output logic data_o
);
    localparam int CW = $clog2(FILTER_LEN) + 1;
    logic [1:0]    csync_q, dsync_q;
    logic [CW-1:0] cnt_q;
    logic          filt_q, fall_q;
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            csync_q <= '1;
            dsync_q <= '1;
            cnt_q   <= '0;
            filt_q  <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            csync_q <= {csync_q[0], ps2_clk_i};
            dsync_q <= {dsync_q[0], ps2_data_i};
            fall_q  <= 1'b0;
            // filtered level flips only after FILTER_LEN consecutive disagreeing samples
            if (csync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_q <= csync_q[1];
                cnt_q  <= '0;
                fall_q <= filt_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end
    assign fall_o = fall_q;
    assign data_o = dsync_q[1];
endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 device-to-host frame receiver that folds E0/F0 prefixes into single decoded key events.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 74_250_000,
    parameter int TIMEOUT_US  = 200,
    parameter int FILTER_LEN  = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [7:0] code_out,
    output logic       valid_out,
    output logic       extended_out,
    output logic       release_out,
    output logic       key_pressed_out,
    output logic       enter_pressed_out,
    output logic       bksp_pressed_out,
    output logic       frame_err_out
);
    localparam int TO_CYC = timeout_cycles(CLK_FREQ_HZ, TIMEOUT_US);
    localparam int TW     = $clog2(TO_CYC) + 1;
    state_e        state_q;
    logic [2:0]    cnt_q;
    logic [7:0]    sh_q, code_q;
    logic [TW-1:0] to_q;
    logic          par_q, ext_q, brk_q;
    logic          valid_q, ext_out_q, rel_q, key_q, enter_q, bksp_q, err_q;
    logic          fall, bit_in, good_d;
    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .ps2_clk_i  (ps2_clk_in),
        .ps2_data_i (ps2_data_in),
        .fall_o     (fall),
        .data_o     (bit_in)
    );
    assign good_d = ((^sh_q) ^ par_q) & bit_in;
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            par_q     <= 1'b0;
            to_q      <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            ext_out_q <= 1'b0;
            rel_q     <= 1'b0;
            key_q     <= 1'b0;
            enter_q   <= 1'b0;
            bksp_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            key_q   <= 1'b0;
            enter_q <= 1'b0;
            bksp_q  <= 1'b0;
            err_q   <= 1'b0;
            if (fall) begin
                to_q <= '0;
                case (state_q)
                    IDLE: begin
                        if (!bit_in) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    DATA: begin
                        sh_q  <= {bit_in, sh_q[7:1]};
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        par_q   <= bit_in;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (!good_d) begin
                            err_q <= 1'b1;
                            ext_q <= 1'b0;
                            brk_q <= 1'b0;
                        end else if (sh_q == SC_EXT) begin
                            ext_q <= 1'b1;
                        end else if (sh_q == SC_BRK) begin
                            brk_q <= 1'b1;
                        end else begin
                            code_q    <= sh_q;
                            ext_out_q <= ext_q;
                            rel_q     <= brk_q;
                            valid_q   <= 1'b1;
                            enter_q   <= !brk_q && sh_q == SC_ENTER;
                            bksp_q    <= !brk_q && !ext_q && sh_q == SC_BKSP;
                            key_q     <= !brk_q && !ext_q && sh_q != SC_ENTER && sh_q != SC_BKSP;
                            ext_q     <= 1'b0;
                            brk_q     <= 1'b0;
                        end
                    end
                endcase
            end else if (state_q != IDLE) begin
                if (to_q == TW'(TO_CYC - 1)) begin
                    to_q    <= '0;
                    state_q <= IDLE;
                    err_q   <= 1'b1;
                    ext_q   <= 1'b0;
                    brk_q   <= 1'b0;
                end else begin
                    to_q <= to_q + TW'(1);
                end
            end
        end
    end
    assign code_out          = code_q;
    assign valid_out         = valid_q;
    assign extended_out      = ext_out_q;
    assign release_out       = rel_q;
    assign key_pressed_out   = key_q;
    assign enter_pressed_out = enter_q;
    assign bksp_pressed_out  = bksp_q;
    assign frame_err_out     = err_q;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: directed and random PS/2 frames checked against a scancode-level event model.
module tb_ps2_scancode_rx;
    localparam int HALF    = 25;
    localparam int TO_WAIT = 15593;  // 210 us of a 74.25 MHz clock
    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code_out;
    logic       valid_out, extended_out, release_out;
    logic       key_pressed_out, enter_pressed_out, bksp_pressed_out, frame_err_out;
    int          checks = 0, passed = 0;
    int          ev_n = 0, err_n = 0, stray = 0;
    logic [12:0] ev_last = '0;
    int          exp_ev = 0, exp_err = 0;
    logic [12:0] exp_last = '0;
    bit          m_ext = 0, m_brk = 0;
    logic [14:0] outs;
    ps2_scancode_rx dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .ps2_clk_in        (ps2_clk),
        .ps2_data_in       (ps2_data),
        .code_out          (code_out),
        .valid_out         (valid_out),
        .extended_out      (extended_out),
        .release_out       (release_out),
        .key_pressed_out   (key_pressed_out),
        .enter_pressed_out (enter_pressed_out),
        .bksp_pressed_out  (bksp_pressed_out),
        .frame_err_out     (frame_err_out)
    );
    always #5 clk_in = ~clk_in;
    assign outs = {code_out, valid_out, extended_out, release_out,
                   key_pressed_out, enter_pressed_out, bksp_pressed_out, frame_err_out};
    always @(negedge clk_in) begin
        if (valid_out) begin
            ev_n++;
            ev_last = {code_out, extended_out, release_out,
                       key_pressed_out, enter_pressed_out, bksp_pressed_out};
        end else if (key_pressed_out || enter_pressed_out || bksp_pressed_out) begin
            stray++;
        end
        if (frame_err_out) err_n++;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(posedge clk_in);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk_in);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask
    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit flip);
        return {1'b1, ~^b ^ flip, b, 1'b0};
    endfunction
    // Scancode-level reference: prefixes set flags, any other byte is one event.
    task automatic model(input logic [7:0] b, input bit good);
        bit mk;
        if (!good) begin
            exp_err++;
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            mk = !m_brk;
            exp_ev++;
            exp_last = {b, m_ext, m_brk,
                        mk && !m_ext && b != 8'h5A && b != 8'h66,
                        mk && b == 8'h5A,
                        mk && !m_ext && b == 8'h66};
            m_ext = 0;
            m_brk = 0;
        end
    endtask
    task automatic compare(input string tag);
        chk({tag, "_events"}, ev_n, exp_ev);
        chk({tag, "_errors"}, err_n, exp_err);
        chk({tag, "_stray"}, stray, 0);
        chk({tag, "_last"}, 32'(ev_last), 32'(exp_last));
    endtask
    task automatic frame(input logic [7:0] b, input bit flip, input string tag);
        send_bits(mk_frame(b, flip), 11);
        model(b, !flip);
        repeat (10) @(posedge clk_in);
        compare(tag);
    endtask
    initial begin
        repeat (5) @(posedge clk_in);
        @(negedge clk_in);
        chk("reset_outs", 32'(outs), 0);
        rst_in = 1'b1;
        repeat (5) @(posedge clk_in);
        frame(8'h1C, 0, "make_1c");
        chk("make_1c_fields", 32'(ev_last), 32'({8'h1C, 5'b00100}));
        frame(8'hF0, 0, "brk_pfx");
        frame(8'h1C, 0, "brk_1c");
        chk("brk_1c_fields", 32'(ev_last), 32'({8'h1C, 5'b01000}));
        frame(8'hE0, 0, "ext_pfx");
        frame(8'h5A, 0, "ext_enter");
        chk("ext_enter_fields", 32'(ev_last), 32'({8'h5A, 5'b10010}));
        frame(8'hE0, 0, "extbrk_pfx1");
        frame(8'hF0, 0, "extbrk_pfx2");
        frame(8'h5A, 0, "extbrk_enter");
        chk("extbrk_fields", 32'(ev_last), 32'({8'h5A, 5'b11000}));
        frame(8'h66, 0, "bksp");
        chk("bksp_fields", 32'(ev_last), 32'({8'h66, 5'b00001}));
        frame(8'h1C, 1, "bad_parity");
        frame(8'h1C, 0, "after_parity");
        send_bits(11'h7FF, 1);
        exp_err++;
        repeat (10) @(posedge clk_in);
        compare("start_err");
        frame(8'hF0, 0, "to_pfx");
        send_bits(mk_frame(8'h66, 0), 6);
        repeat (TO_WAIT) @(posedge clk_in);
        model(8'h00, 0);
        compare("timeout");
        frame(8'h66, 0, "after_timeout");
        chk("after_timeout_fields", 32'(ev_last), 32'({8'h66, 5'b00001}));
        frame(8'hF0, 0, "rst_pfx");
        send_bits(mk_frame(8'h1C, 0), 5);
        @(negedge clk_in) rst_in = 1'b0;
        @(negedge clk_in) rst_in = 1'b1;
        chk("mid_reset_outs", 32'(outs), 0);
        m_ext = 0;
        m_brk = 0;
        repeat (10) @(posedge clk_in);
        compare("mid_reset");
        frame(8'h1C, 0, "after_reset");
        chk("after_reset_fields", 32'(ev_last), 32'({8'h1C, 5'b00100}));
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            int r;
            r = $urandom_range(0, 7);
            b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : (r == 2) ? 8'h5A :
                (r == 3) ? 8'h66 : 8'($urandom_range(0, 255));
            frame(b, $urandom_range(0, 7) == 0, "random");
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
- Upstream keyboard front end for the terminal path. It receives PS/2 device-to-host frames on the raw keyboard pins.
- It validates each frame (start, odd parity, stop, timeout) and folds the E0/F0 prefix bytes into flags on a single decoded event.
- Its per-event pulses (key/enter/backspace) and 8-bit code feed translate_keypress and terminal_controller in the pixel-clock domain.

Parameters:
- CLK_FREQ_HZ, 74_250_000, frequency of clk_in; used to size the timeout counter.
- TIMEOUT_US, 200, maximum gap between falling edges inside a frame before the frame is abandoned.
- FILTER_LEN, 4, number of consecutive equal synced samples required before the filtered ps2 clock changes level.

Ports:
- clk_in, input, 1, system clock (pixel clock).
- rst_in, input, 1, synchronous reset, active-low.
- ps2_clk_in, input, 1, raw PS/2 clock (asynchronous).
- ps2_data_in, input, 1, raw PS/2 data (asynchronous).
- code_out, output, 8, scancode byte of the last event; held until the next event.
- valid_out, output, 1, one-cycle pulse; a decoded event is on code_out/extended_out/release_out.
- extended_out, output, 1, event was preceded by E0.
- release_out, output, 1, event was preceded by F0 (break).
- key_pressed_out, output, 1, one-cycle pulse on a make of any non-extended code other than 0x5A and 0x66.
- enter_pressed_out, output, 1, one-cycle pulse on a make of 0x5A (extended or not).
- bksp_pressed_out, output, 1, one-cycle pulse on a make of non-extended 0x66.
- frame_err_out, output, 1, one-cycle pulse on a start, parity, stop or timeout error.

Behaviour:
- Reset (rst_in==0 at a clk_in edge):
  - All outputs go to 0 and code_out to 8'h00.
  - The frame FSM goes to IDLE; bit count, shift register, flags and timeout counter are cleared.
  - The filtered clock and synchronizers are set to 1.
  - Reset mid-frame discards the partial frame with no error pulse.
- Input conditioning:
  - ps2_clk_in and ps2_data_in each pass through 2-FF synchronizers.
  - The synced clock passes through the FILTER_LEN glitch filter.
  - A falling edge is filtered clock 1->0. Data is sampled from synced data in the cycle the edge is detected.
- Frame FSM (one transition per falling edge):
  - IDLE: if sampled bit==0, go to DATA and set bit count=0. Otherwise stay in IDLE and pulse frame_err_out.
  - DATA: shift the bit in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: store the bit and go to STOP.
  - STOP: the frame is good when (XOR of the 8 data bits ^ parity)==1 and the stop bit==1.
    - Good frame: pass the byte to the decoder and go to IDLE.
    - Bad frame: pulse frame_err_out, clear the E0/F0 flags, go to IDLE.
- Timeout:
  - The counter runs in any state other than IDLE and resets on every falling edge.
  - At CLK_FREQ_HZ*TIMEOUT_US/1e6 cycles: pulse frame_err_out, clear the flags, go to IDLE.
  - Width of the counter is $clog2 of that terminal count plus 1.
- Decoder (acts in the cycle after a good STOP):
  - Byte 0xE0: set the ext flag; no event.
  - Byte 0xF0: set the brk flag; no event.
  - Any other byte:
    - Register code_out and set extended_out=ext and release_out=brk.
    - Pulse valid_out; the same cycle also pulses the applicable key/enter/bksp output, only when brk==0.
    - Clear both flags.
  - Exactly one of key_pressed_out/enter_pressed_out/bksp_pressed_out pulses per make event, except extended makes other than E0 5A, which pulse none.
- Latency:
  - valid_out asserts 1 cycle after the cycle in which the stop-bit falling edge is detected.
  - Pin-to-detection takes 2 synchronizer cycles plus FILTER_LEN cycles.
- Typematic repeats (repeated makes) each produce a full event.
- A prefix followed by an error is discarded.
- Back-to-back frames with no idle gap beyond the stop bit are accepted.

Decomposition:
- Shared package ps2_pkg:
  - State enum {IDLE, DATA, PARITY, STOP}.
  - Constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_ENTER=8'h5A, SC_BKSP=8'h66.
- Sub-module ps2_sync_filter: the 2-FF synchronizers plus the FILTER_LEN glitch filter; outputs clean clock, falling-edge strobe and synced data.

Test Plan:
- Frame byte 0x1C (odd parity bit=0), stop=1 -> one valid_out with code_out=8'h1C, extended_out=0, release_out=0, key_pressed_out=1.
- Frames F0,1C -> one event, code_out=8'h1C, release_out=1; key_pressed_out, enter_pressed_out and bksp_pressed_out stay 0.
- Frames E0,5A then E0,F0,5A -> event 1 has extended_out=1 and enter_pressed_out=1. Event 2 has extended_out=1, release_out=1 and no press pulse. 0x66 -> bksp_pressed_out=1.
- Byte 0x1C with flipped parity -> frame_err_out pulse, no valid_out. A following good 0x1C frame decodes normally.
- Stop after 5 data bits for TIMEOUT_US+10us -> frame_err_out pulse and FSM in IDLE. A following good 0x66 frame -> bksp_pressed_out=1.
- Drive rst_in=0 for one cycle mid-frame after F0 -> no outputs. Then 0x1C -> release_out=0, key_pressed_out=1.
